// File: rtl/ray_dispatcher_if.sv
// Ray dispatcher bus: ray issue towards the tracer, tracer response back,
// and the framebuffer write port. The dispatcher is the master.
interface ray_dispatcher_if;
   logic [27:0] ray_init;
   logic [27:0] ray_dir;
   logic        ray_valid;
   logic        tracer_ret;
   logic [11:0] tracer_dout;
   logic        collision_sig;
   logic        vram_we;
   logic [18:0] vram_addr;
   logic [11:0] vram_din;

   modport master (
      output ray_init, ray_dir, ray_valid, vram_we, vram_addr, vram_din,
      input  tracer_ret, tracer_dout, collision_sig
   );

   modport slave (
      input  ray_init, ray_dir, ray_valid, vram_we, vram_addr, vram_din,
      output tracer_ret, tracer_dout, collision_sig
   );
endinterface

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: walks every pixel of a frame, issues one ray per pixel to
// the tracer, waits for the shaded colour and writes it to the framebuffer.
// Optional feature: define DISPATCH_TIMEOUT_EN to give up on a tracer that
// stays silent for TIMEOUT cycles (pixel written black, no collision count).
module ray_dispatcher #(
   parameter int          H_RES   = 640,
   parameter int          V_RES   = 480,
   parameter logic [8:0]  FOCAL   = 9'd255,
   parameter logic [27:0] CAM_POS = 28'd0,
   parameter int          TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   ray_dispatcher_if.master   bus,
   output logic               busy,
   output logic               frame_done,
   output logic [18:0]        collision_cnt
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, NEXT, DONE} state_t;

   localparam logic [9:0]  X_LAST  = 10'(H_RES - 1);
   localparam logic [8:0]  Y_LAST  = 9'(V_RES - 1);
   localparam logic [9:0]  X_HALF  = 10'(H_RES / 2);
   localparam logic [8:0]  Y_HALF  = 9'(V_RES / 2);
   localparam logic [18:0] H_RES_W = 19'(H_RES);

   state_t      state_reg;
   logic [9:0]  x_reg;
   logic [8:0]  y_reg;
   logic [11:0] colour_reg;

   // Response actually taken this cycle in WAIT (tracer answer or timeout).
   logic        resp_take;
   logic [11:0] resp_colour;
   logic        resp_hit;

`ifdef DISPATCH_TIMEOUT_EN
   localparam int                WC_W      = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(TIMEOUT - 1);
   logic [WC_W-1:0]              wait_reg;
`endif

   // Ray direction points from the screen centre towards the pixel.
   function automatic logic [27:0] dir_of(input logic [9:0] px, input logic [8:0] py);
      return {px - X_HALF, py - Y_HALF, FOCAL};
   endfunction

   // Row-major framebuffer address.
   function automatic logic [18:0] addr_of(input logic [9:0] px, input logic [8:0] py);
      return ({10'd0, py} * H_RES_W) + {9'd0, px};
   endfunction

   // Select between a real tracer answer and an expired wait.
   always_comb begin
      resp_take   = bus.tracer_ret;
      resp_colour = bus.tracer_dout;
      resp_hit    = bus.collision_sig;
`ifdef DISPATCH_TIMEOUT_EN
      if (!bus.tracer_ret && (wait_reg == WAIT_LAST)) begin
         resp_take   = 1'b1;
         resp_colour = 12'h000;
         resp_hit    = 1'b0;
      end
`endif
   end

   // Framebuffer data is the colour captured at the end of WAIT.
   assign bus.vram_din = colour_reg;

   // Frame walker FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         x_reg         <= '0;
         y_reg         <= '0;
         colour_reg    <= '0;
         collision_cnt <= '0;
         bus.ray_init  <= '0;
         bus.ray_dir   <= '0;
         bus.ray_valid <= 1'b0;
         bus.vram_we   <= 1'b0;
         bus.vram_addr <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
         wait_reg      <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  x_reg         <= '0;
                  y_reg         <= '0;
                  collision_cnt <= '0;
                  busy          <= 1'b1;
                  bus.ray_init  <= CAM_POS;
                  bus.ray_dir   <= dir_of(10'd0, 9'd0);
                  bus.ray_valid <= 1'b1;
                  state_reg     <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef DISPATCH_TIMEOUT_EN
               wait_reg  <= '0;
`endif
               state_reg <= WAIT;
            end
            WAIT: begin
               if (resp_take) begin
                  colour_reg <= resp_colour;
                  if (resp_hit && !(&collision_cnt))
                     collision_cnt <= collision_cnt + 19'd1;
                  bus.ray_valid <= 1'b0;
                  bus.vram_we   <= 1'b1;
                  bus.vram_addr <= addr_of(x_reg, y_reg);
                  state_reg     <= WRITE;
               end
`ifdef DISPATCH_TIMEOUT_EN
               else begin
                  wait_reg <= wait_reg + 1'b1;
               end
`endif
            end
            WRITE: begin
               bus.vram_we <= 1'b0;
               state_reg   <= NEXT;
            end
            NEXT: begin
               if (x_reg == X_LAST) begin
                  if (y_reg == Y_LAST) begin
                     frame_done <= 1'b1;
                     state_reg  <= DONE;
                  end else begin
                     x_reg         <= '0;
                     y_reg         <= y_reg + 9'd1;
                     bus.ray_dir   <= dir_of(10'd0, y_reg + 9'd1);
                     bus.ray_valid <= 1'b1;
                     state_reg     <= ISSUE;
                  end
               end else begin
                  x_reg         <= x_reg + 10'd1;
                  bus.ray_dir   <= dir_of(x_reg + 10'd1, y_reg);
                  bus.ray_valid <= 1'b1;
                  state_reg     <= ISSUE;
               end
            end
            DONE: begin
               frame_done <= 1'b0;
               busy       <= 1'b0;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
